// File: rtl/alu_reg_if.sv
// Operand/result bundle between an ALU client and alu_reg.
// Requester drives operands and op select; the ALU returns hi/lo/zero.
interface alu_reg_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  shamt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;

    modport master (
        output a, b, op, shamt,
        input  hi, lo, zero
    );

    modport slave (
        input  a, b, op, shamt,
        output hi, lo, zero
    );
endinterface

// File: rtl/alu_reg.sv
// alu_reg: two-stage registered MIPS-style ALU with multiply and divide.
// Latency 2 cycles, one op per cycle, no backpressure (always accepts).
module alu_reg (
    input  logic     clk,
    input  logic     reset,
    alu_reg_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_XOR   = 4'd2,
        OP_NOR   = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_DIV   = 4'd13,
        OP_DIVU  = 4'd14,
        OP_RSVD  = 4'd15
    } op_t;

    // Restoring long division; returns {remainder, quotient}.
    function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
        logic [32:0] r;
        logic [31:0] q;
        r = 33'd0;
        q = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            r = {r[31:0], n[i]};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[i] = 1'b1;
            end
        end
        return {r[31:0], q};
    endfunction

    // Stage 1: operand capture. s1_vld keeps the reset-cleared operands
    // from ever being published as a result.
    logic        s1_vld;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    op_t         s1_op;
    logic [4:0]  s1_shamt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_a     <= 32'h0;
            s1_b     <= 32'h0;
            s1_op    <= OP_AND;
            s1_shamt <= 5'h0;
        end else begin
            s1_vld   <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= op_t'(bus.op);
            s1_shamt <= bus.shamt;
        end
    end

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [63:0] div_rq;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        div_zero;

    assign prod_s = $signed({{32{s1_a[31]}}, s1_a}) * $signed({{32{s1_b[31]}}, s1_b});
    assign prod_u = {32'h0, s1_a} * {32'h0, s1_b};

    // One shared unsigned divider; signed divide runs on magnitudes and
    // fixes signs afterwards. The 0x80000000 / -1 case falls out naturally.
    assign mag_a  = s1_a[31] ? (~s1_a + 32'd1) : s1_a;
    assign mag_b  = s1_b[31] ? (~s1_b + 32'd1) : s1_b;
    assign div_n  = (s1_op == OP_DIV) ? mag_a : s1_a;
    assign div_d  = (s1_op == OP_DIV) ? mag_b : s1_b;
    assign div_rq = udivmod(div_n, div_d);
    assign div_q  = div_rq[31:0];
    assign div_r  = div_rq[63:32];
    assign q_s    = (s1_a[31] ^ s1_b[31]) ? (~div_q + 32'd1) : div_q;
    assign r_s    = s1_a[31] ? (~div_r + 32'd1) : div_r;
    assign div_zero = (s1_b == 32'h0);

    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        res_hi = 32'h0;
        res_lo = 32'h0;
        case (s1_op)
            OP_AND:   res_lo = s1_a & s1_b;
            OP_OR:    res_lo = s1_a | s1_b;
            OP_XOR:   res_lo = s1_a ^ s1_b;
            OP_NOR:   res_lo = ~(s1_a | s1_b);
            OP_ADD:   res_lo = s1_a + s1_b;
            OP_SUB:   res_lo = s1_a - s1_b;
            OP_SLT:   res_lo = {31'h0, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU:  res_lo = {31'h0, (s1_a < s1_b)};
            OP_SLL:   res_lo = s1_b << s1_shamt;
            OP_SRL:   res_lo = s1_b >> s1_shamt;
            OP_SRA:   res_lo = $unsigned($signed(s1_b) >>> s1_shamt);
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (div_zero) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = s1_a;
                end else begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
            end
            OP_DIVU: begin
                if (div_zero) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = s1_a;
                end else begin
                    res_lo = div_q;
                    res_hi = div_r;
                end
            end
            default: begin
                res_hi = 32'h0;
                res_lo = 32'h0;
            end
        endcase
    end

    // Stage 2: result registers; zero looks at lo only.
    always_ff @(posedge clk) begin
        if (reset || !s1_vld) begin
            bus.hi   <= 32'h0;
            bus.lo   <= 32'h0;
            bus.zero <= 1'b0;
        end else begin
            bus.hi   <= res_hi;
            bus.lo   <= res_lo;
            bus.zero <= (res_lo == 32'h0);
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
// Testbench for alu_reg: directed vectors plus random traffic with resets.
module tb_alu_reg;

    logic clk = 1'b0;
    logic reset;

    alu_reg_if bus ();

    alu_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam int MAXC = 1024;
    logic [31:0] h_a   [MAXC];
    logic [31:0] h_b   [MAXC];
    logic [3:0]  h_op  [MAXC];
    logic [4:0]  h_sh  [MAXC];
    logic        h_rst [MAXC];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
    } vec_t;

    vec_t vt [14];

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        logic [63:0] t;
        logic [31:0] hi;
        logic [31:0] lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            4'd0:  lo = a & b;
            4'd1:  lo = a | b;
            4'd2:  lo = a ^ b;
            4'd3:  lo = ~(a | b);
            4'd4:  lo = a + b;
            4'd5:  lo = a - b;
            4'd6:  lo = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  lo = (a < b) ? 32'd1 : 32'd0;
            4'd8:  lo = b << sh;
            4'd9:  lo = b >> sh;
            4'd10: begin
                t  = sb >>> sh;
                lo = t[31:0];
            end
            4'd11: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            4'd12: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            4'd13: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    t  = q;
                    lo = t[31:0];
                    t  = r;
                    hi = t[31:0];
                end
            end
            4'd14: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                hi = 32'h0;
                lo = 32'h0;
            end
        endcase
        return {hi, lo};
    endfunction

    // Apply one cycle of inputs, then check outputs against the model:
    // the value after edge k comes from inputs of edge k-1 unless reset hit either edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] sh);
        logic [31:0] ph;
        logic [31:0] pl;
        logic        pz;
        logic [63:0] e;
        logic        ez;
        logic        prev_rst;
        ph = bus.hi;
        pl = bus.lo;
        pz = bus.zero;
        reset     = r;
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.shamt = sh;
        h_a[cyc]   = a;
        h_b[cyc]   = b;
        h_op[cyc]  = op;
        h_sh[cyc]  = sh;
        h_rst[cyc] = r;
        #1;
        checks++;
        assert ({bus.hi, bus.lo, bus.zero} === {ph, pl, pz})
        else begin
            errors++;
            $error("FAIL comb_path cyc=%0d got hi=%h lo=%h z=%b want hi=%h lo=%h z=%b",
                   cyc, bus.hi, bus.lo, bus.zero, ph, pl, pz);
        end
        @(posedge clk);
        #1;
        prev_rst = (cyc == 0) ? 1'b1 : h_rst[cyc-1];
        if (h_rst[cyc] || prev_rst) begin
            e  = 64'h0;
            ez = 1'b0;
        end else begin
            e  = ref_alu(h_a[cyc-1], h_b[cyc-1], h_op[cyc-1], h_sh[cyc-1]);
            ez = (e[31:0] == 32'h0);
        end
        checks++;
        assert (bus.hi === e[63:32])
        else begin
            errors++;
            $error("FAIL hi cyc=%0d got %h want %h", cyc, bus.hi, e[63:32]);
        end
        checks++;
        assert (bus.lo === e[31:0])
        else begin
            errors++;
            $error("FAIL lo cyc=%0d got %h want %h", cyc, bus.lo, e[31:0]);
        end
        checks++;
        assert (bus.zero === ez)
        else begin
            errors++;
            $error("FAIL zero cyc=%0d got %b want %b", cyc, bus.zero, ez);
        end
        cyc++;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        vt[0]  = '{4'd4,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         32'h0,         1'b1};
        vt[1]  = '{4'd11, 32'hFFFF_FFFE, 32'h3,         5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vt[2]  = '{4'd12, 32'hFFFF_FFFE, 32'h3,         5'd0,  32'h2,         32'hFFFF_FFFA, 1'b0};
        vt[3]  = '{4'd13, 32'hFFFF_FFF9, 32'h2,         5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vt[4]  = '{4'd14, 32'h7,         32'h0,         5'd0,  32'h7,         32'hFFFF_FFFF, 1'b0};
        vt[5]  = '{4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0,         32'h8000_0000, 1'b0};
        vt[6]  = '{4'd10, 32'h0,         32'h8000_0000, 5'd4,  32'h0,         32'hF800_0000, 1'b0};
        vt[7]  = '{4'd9,  32'h0,         32'h8000_0000, 5'd4,  32'h0,         32'h0800_0000, 1'b0};
        vt[8]  = '{4'd8,  32'h0,         32'h1,         5'd31, 32'h0,         32'h8000_0000, 1'b0};
        vt[9]  = '{4'd6,  32'hFFFF_FFFF, 32'h0,         5'd0,  32'h0,         32'h1,         1'b0};
        vt[10] = '{4'd7,  32'hFFFF_FFFF, 32'h0,         5'd0,  32'h0,         32'h0,         1'b1};
        vt[11] = '{4'd15, 32'h5,         32'h7,         5'd3,  32'h0,         32'h0,         1'b1};
        vt[12] = '{4'd13, 32'h5,         32'h0,         5'd0,  32'h5,         32'hFFFF_FFFF, 1'b0};
        vt[13] = '{4'd3,  32'h0,         32'h0,         5'd0,  32'h0,         32'hFFFF_FFFF, 1'b0};

        step(1'b1, 32'h1234_5678, 32'h1, 4'd4, 5'd0);
        step(1'b1, 32'h1234_5678, 32'h1, 4'd4, 5'd0);

        // Directed vectors back to back; each result is due one step later.
        for (int i = 0; i <= 14; i++) begin
            if (i < 14)
                step(1'b0, vt[i].a, vt[i].b, vt[i].op, vt[i].sh);
            else
                step(1'b0, 32'h0, 32'h1, 4'd1, 5'd0);
            if (i > 0) begin
                checks++;
                assert ({bus.hi, bus.lo, bus.zero} === {vt[i-1].hi, vt[i-1].lo, vt[i-1].z})
                else begin
                    errors++;
                    $error("FAIL vec%0d got hi=%h lo=%h z=%b want hi=%h lo=%h z=%b", i - 1,
                           bus.hi, bus.lo, bus.zero, vt[i-1].hi, vt[i-1].lo, vt[i-1].z);
                end
            end
        end

        // Mid-stream single-cycle reset discards in-flight work.
        step(1'b0, 32'h10, 32'h20, 4'd4, 5'd0);
        step(1'b0, 32'h30, 32'h40, 4'd4, 5'd0);
        step(1'b1, 32'h50, 32'h60, 4'd4, 5'd0);
        step(1'b0, 32'h0,  32'h0,  4'd0, 5'd0);
        checks++;
        assert ({bus.hi, bus.lo, bus.zero} === {32'h0, 32'h0, 1'b0})
        else begin
            errors++;
            $error("FAIL post_reset got hi=%h lo=%h z=%b want 0/0/0", bus.hi, bus.lo, bus.zero);
        end
        step(1'b0, 32'h7,  32'h8,  4'd4, 5'd0);
        step(1'b0, 32'h7,  32'h8,  4'd4, 5'd0);

        // Constant inputs hold constant outputs.
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'hDEAD_BEEF, 32'h0000_0123, 4'd11, 5'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), rand_operand(), rand_operand(),
                 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end
        step(1'b0, 32'h0, 32'h0, 4'd0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
ALU_REG -- requirements
Module: alu_reg

Interface
REQ-001: Parameters: none; all widths fixed as listed below.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004: a  input  32  operand A (rs).
REQ-005: b  input  32  operand B (rt); shift source for shift ops.
REQ-006: op  input  4  operation select (encoding in REQ-011).
REQ-007: shamt  input  5  shift amount, 0..31.
REQ-008: hi  output  32  upper result word (multiply high half / divide remainder, else 0).
REQ-009: lo  output  32  lower result word (main result).
REQ-010: zero  output  1  1 when the registered lo equals 32'h0.

Function
REQ-011: The op encoding SHALL be:
- 0 AND: lo=a&b
- 1 OR: lo=a|b
- 2 XOR: lo=a^b
- 3 NOR: lo=~(a|b)
- 4 ADD: lo=a+b mod 2^32, no overflow trap
- 5 SUB: lo=a-b mod 2^32
- 6 SLT: lo=1 if signed a<signed b, else 0
- 7 SLTU: lo=1 if unsigned a<b, else 0
- 8 SLL: lo=b<<shamt
- 9 SRL: lo=b>>shamt, zero fill
- 10 SRA: lo=b>>>shamt, sign fill
- 11 MULT: {hi,lo}=signed 64-bit a*b
- 12 MULTU: {hi,lo}=unsigned 64-bit a*b
- 13 DIV: lo=signed quotient truncated toward zero; hi=remainder with sign of a
- 14 DIVU: lo=unsigned quotient; hi=unsigned remainder
- 15 reserved: hi=0, lo=0
REQ-012: For ops 0-10 hi SHALL be 32'h0.
REQ-013: Divide by zero (op 13/14, b=0): lo=32'hFFFFFFFF, hi=a.
REQ-014: Signed overflow divide (a=32'h80000000, b=32'hFFFFFFFF, op 13): lo=32'h80000000, hi=0.
REQ-015: zero SHALL be derived from the lo result only, independent of hi.
REQ-016: Pipeline: stage 1 registers a, b, op, shamt on rising clk; stage 2 computes the result combinationally from the stage-1 registers and registers hi, lo, zero on the next rising clk.
REQ-017: Latency SHALL be exactly 2 clk cycles from inputs sampled to outputs valid; throughput one operation per cycle; no handshake.
REQ-018: Outputs SHALL change only on rising clk edges, with no combinational path from input to output.
REQ-019: Inputs held constant SHALL give constant outputs from the 2nd edge onward.

Reset
REQ-020: While reset=1 at a rising edge, the stage-1 registers, hi, lo and zero SHALL all clear to 0.
REQ-021: Reset SHALL take priority over input capture; the first operation presented in the cycle reset deasserts is captured on the next rising edge and appears 2 cycles later.
REQ-022: Reset asserted mid-stream SHALL discard all in-flight operations; no stale result appears after reset.

Verification
REQ-023: op=4, a=32'hFFFFFFFF, b=1 -> after 2 clks lo=0, hi=0, zero=1.
REQ-024: op=11, a=32'hFFFFFFFE (-2), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, zero=0; op=12 with same operands -> hi=2, lo=32'hFFFFFFFA.
REQ-025: op=13, a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; op=14, a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-026: op=10, b=32'h80000000, shamt=4 -> lo=32'hF8000000; op=9 with same inputs -> lo=32'h08000000; op=8, b=1, shamt=31 -> lo=32'h80000000.
REQ-027: op=6, a=32'hFFFFFFFF, b=0 -> lo=1; op=7 with same inputs -> lo=0, zero=1.
REQ-028: back-to-back ops on consecutive edges, then reset for 1 cycle -> each result appears exactly 2 cycles after its input; after reset hi=lo=0, zero=0 until new results arrive.
